// File: rtl/spi_wb_master_pkg.sv
// Shared constants for the wishbone SPI master: FSM encodings, register map, CONFIG layout.
// Latency: none (definitions only); backpressure: not applicable.
package spi_wb_master_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_CONFIG = 3'd1;
    localparam logic [2:0] REG_DATA   = 3'd4;

    // CONFIG register layout: bit0 CPOL, bit1 CPHA.
    typedef struct packed {
        logic cpha;
        logic cpol;
    } cfg_t;

    function automatic int calc_half(input int clk_hz, input int spi_hz);
        int h;
        h = (clk_hz + 2 * spi_hz - 1) / (2 * spi_hz);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/spi_wb_master_if.sv
// 8-bit wishbone register-bus port bundle for the SPI master.
// Latency: combinational wires only; backpressure: none, ack is zero-wait.
interface spi_wb_master_if;

    logic       wb_stb_i;
    logic       wb_cyc_i;
    logic       wb_we_i;
    logic [7:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/spi_edge_timer.sv
// Half-period divider: counts 0..HALF-1 while run is high and pulses tick on the wrap cycle.
// Latency: first tick HALF cycles after run rises; backpressure: none.
module spi_edge_timer #(
    parameter int HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_wb_master.sv
// Wishbone-controlled SPI master, runtime CPOL/CPHA; SPI_WB_MISO_EN enables MISO capture into RX regs.
// Latency: start to IDLE takes HALF*(2*DATA_BITS+3) clocks; no backpressure, writes outside IDLE are dropped.
module spi_wb_master
    import spi_wb_master_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 125000000,
    parameter int SPI_FREQ        = 2000000,
    parameter int DATA_BITS       = 16,
    parameter int NUM_CS          = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_wb_master_if.slave    wb,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs
);

    localparam int HALF = calc_half(CLOCK_FREQUENCY, SPI_FREQ);
    localparam int NB   = DATA_BITS / 8;
    localparam int EW   = $clog2(2 * DATA_BITS + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_BITS);

    logic [2:0]           state_q, state_d;
    cfg_t                 cfg_q, cfg_d;
    logic [DATA_BITS-1:0] tx_q, tx_d, tx_sh_q, tx_sh_d, rd_word;
    logic [EW-1:0]        edge_q, edge_d, edge_n;
    logic                 sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
    logic [NUM_CS-1:0]    cs_q, cs_d;
    logic                 wr_en, is_idle, start, tick, sample_edge;
    logic [2:0]           adr;
    logic [1:0]           cs_idx;
    logic [7:0]           rd_dat;
    logic [4:0]           unused_adr;

    assign wr_en       = wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i;
    assign adr         = wb.wb_adr_i[2:0];
    assign unused_adr  = wb.wb_adr_i[7:3];
    assign cs_idx      = wb.wb_dat_i[2:1];
    assign is_idle     = (state_q == S_IDLE);
    assign start       = wr_en && (adr == REG_CTRL) && wb.wb_dat_i[0] && is_idle
                         && (int'(cs_idx) < NUM_CS);
    assign edge_n      = edge_q + 1'b1;
    // Odd edges are leading; CPHA=0 samples on leading, CPHA=1 on trailing.
    assign sample_edge = edge_n[0] ^ cfg_q.cpha;

    spi_edge_timer #(.HALF(HALF)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (!is_idle),
        .tick (tick)
    );

`ifdef SPI_WB_MISO_EN
    logic [DATA_BITS-1:0] rx_q, rx_d, rx_sh_q, rx_sh_d;
    assign rd_word = rx_q;
`else
    logic unused_miso;
    assign unused_miso = miso;
    assign rd_word     = tx_q;
`endif

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        tx_d    = tx_q;
        tx_sh_d = tx_sh_q;
        edge_d  = edge_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done_d  = done_q;
        cs_d    = cs_q;
`ifdef SPI_WB_MISO_EN
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
`endif
        if (wr_en && is_idle) begin
            if (adr == REG_CONFIG) begin
                cfg_d = cfg_t'(wb.wb_dat_i[1:0]);
            end
            if (adr >= REG_DATA) begin
                for (int k = 0; k < NB; k++) begin
                    if (adr[1:0] == 2'(k)) begin
                        tx_d[8*k +: 8] = wb.wb_dat_i;
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                // Follow a CONFIG write on the same edge so sclk idles at the new CPOL next cycle.
                sclk_d = cfg_d.cpol;
                if (start) begin
                    state_d = S_SETUP;
                    tx_sh_d = tx_q;
                    mosi_d  = tx_q[DATA_BITS-1];
                    done_d  = 1'b0;
                    edge_d  = '0;
                    cs_d    = ~(NUM_CS'(1) << cs_idx);
`ifdef SPI_WB_MISO_EN
                    rx_sh_d = '0;
`endif
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    edge_d = edge_n;
                    sclk_d = ~sclk_q;
                    if (sample_edge) begin
`ifdef SPI_WB_MISO_EN
                        rx_sh_d = {rx_sh_q[DATA_BITS-2:0], miso};
`endif
                    end else if (cfg_q.cpha) begin
                        mosi_d  = tx_sh_q[DATA_BITS-1];
                        tx_sh_d = tx_sh_q << 1;
                    end else if (edge_n != LAST_EDGE) begin
                        mosi_d  = tx_sh_q[DATA_BITS-2];
                        tx_sh_d = tx_sh_q << 1;
                    end
                    if (edge_n == LAST_EDGE) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    cs_d    = '1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`ifdef SPI_WB_MISO_EN
                    rx_d    = rx_sh_q;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = '1;
                sclk_d  = cfg_q.cpol;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            tx_q    <= '0;
            tx_sh_q <= '0;
            edge_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= '1;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            tx_q    <= tx_d;
            tx_sh_q <= tx_sh_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
        end
    end

`ifdef SPI_WB_MISO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q    <= '0;
            rx_sh_q <= '0;
        end else begin
            rx_q    <= rx_d;
            rx_sh_q <= rx_sh_d;
        end
    end
`endif

    always_comb begin
        rd_dat = '0;
        case (adr)
            REG_CTRL:   rd_dat = {2'b00, state_q[1:0], 2'b00, done_q, ~is_idle};
            REG_CONFIG: rd_dat = {6'b0, cfg_q};
            default: begin
                if (adr >= REG_DATA) begin
                    for (int k = 0; k < NB; k++) begin
                        if (adr[1:0] == 2'(k)) begin
                            rd_dat = rd_word[8*k +: 8];
                        end
                    end
                end
            end
        endcase
    end

    assign wb.wb_dat_o = rd_dat;
    assign wb.wb_ack_o = wb.wb_cyc_i & wb.wb_stb_i;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign cs          = cs_q;

endmodule

// File: tb/tb_spi_wb_master.sv
// Self-checking bench for spi_wb_master: SPI pin monitor plus slave model, compared against spec-level expectations.
module tb_spi_wb_master;

    localparam int DB   = 16;
    localparam int NCS  = 2;
    localparam int HALF = 32;
    localparam int XFER = HALF * (2 * DB + 3);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           miso = 1'b0;
    logic           sclk, mosi;
    logic [NCS-1:0] cs;

    spi_wb_master_if bus();

    spi_wb_master #(
        .CLOCK_FREQUENCY (125000000),
        .SPI_FREQ        (2000000),
        .DATA_BITS       (DB),
        .NUM_CS          (NCS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .wb   (bus),
        .sclk (sclk),
        .mosi (mosi),
        .miso (miso),
        .cs   (cs)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Pin-level monitor and slave model
    int             mon_toggles = 0, mon_samples = 0, mon_rises = 0, mon_bad_gap = 0;
    int unsigned    last_rise = 0;
    logic [31:0]    mon_mosi = '0;
    logic [NCS-1:0] mon_cs_low = '0;
    logic [NCS-1:0] prev_cs = '1;
    logic           prev_sclk = 1'b0;
    logic [DB-1:0]  slave_word = '0, slave_sh = '0;
    bit             m_cpol = 1'b0, m_cpha = 1'b0;

    always @(sclk or cs) begin
        if (cs !== prev_cs) begin
            if (prev_cs === '1 && cs !== '1 && !$isunknown(cs)) begin
                mon_toggles = 0; mon_samples = 0; mon_rises = 0; mon_bad_gap = 0;
                mon_mosi = '0; mon_cs_low = ~cs;
                slave_sh = slave_word; miso = slave_word[DB-1];
            end else if (!$isunknown(cs)) begin
                mon_cs_low = mon_cs_low | ~cs;
            end
            prev_cs = cs;
        end
        if (sclk !== prev_sclk) begin
            if (cs !== '1 && !$isunknown(cs) && !$isunknown(sclk)) begin
                mon_toggles++;
                if (sclk) begin
                    if (mon_rises > 0 && (cyc - last_rise) != 2 * HALF) mon_bad_gap++;
                    last_rise = cyc;
                    mon_rises++;
                end
                if (sclk == (m_cpol == m_cpha)) begin
                    mon_samples++;
                    mon_mosi = {mon_mosi[30:0], mosi};
                    slave_sh = slave_sh << 1;
                    miso     = slave_sh[DB-1];
                end
            end
            prev_sclk = sclk;
        end
    end

    // Expected adr4..7 readback: captured slave word with MISO capture, else the TX word; beyond the width reads 0.
    function automatic logic [7:0] exp_byte(input int k, input logic [DB-1:0] tx, input logic [DB-1:0] slv);
        logic [DB-1:0] w;
`ifdef SPI_WB_MISO_EN
        w = slv;
`else
        w = tx;
`endif
        if (k >= DB / 8) return 8'h00;
        return w[8*k +: 8];
    endfunction

    task automatic wb_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = a;    bus.wb_dat_i = d;
        @(posedge clk);
        #1;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [7:0] d, output logic ack);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = a;
        #1;
        d = bus.wb_dat_o; ack = bus.wb_ack_o;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    endtask

    // Leaves the caller 1 time unit after the posedge that first shows busy=0.
    task automatic wait_idle(output bit timed_out);
        logic [7:0] d;
        logic       a;
        timed_out = 1'b0;
        for (int n = 0; n < 4 * XFER; n++) begin
            @(posedge clk);
            #1;
            wb_read(8'h00, d, a);
            if (!d[0]) return;
        end
        timed_out = 1'b1;
    endtask

    task automatic setup_and_start(input logic [DB-1:0] tx, input logic [1:0] mode,
                                   input logic [1:0] csidx, input logic [DB-1:0] slv,
                                   output int unsigned t0);
        m_cpol = mode[0]; m_cpha = mode[1]; slave_word = slv;
        wb_write(8'h01, {6'b0, mode});
        for (int k = 0; k < DB / 8; k++) wb_write(8'(4 + k), tx[8*k +: 8]);
        wb_write(8'h00, {5'b0, csidx, 1'b1});
        t0 = cyc;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic       a;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (cs !== 2'b11) begin n_fail++; $display("FAIL reset_cs got=%b exp=11", cs); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        n_checks++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        wb_read(8'h00, d, a);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status got=%h exp=00", d); end
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL reset_ack got=%b exp=1", a); end
        wb_read(8'h01, d, a);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_config got=%h exp=00", d); end
        wb_read(8'h04, d, a);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_data0 got=%h exp=00", d); end
    endtask

    task automatic test_mode0;
        logic [7:0]    d;
        logic          a;
        bit            to;
        int unsigned   t0, el;
        logic [DB-1:0] slv;
        slv = DB'($urandom);
        setup_and_start(16'hA53C, 2'b00, 2'd0, slv, t0);
        n_checks++; if (cs !== 2'b10) begin n_fail++; $display("FAIL m0_cs_low got=%b exp=10", cs); end
        wait_idle(to);
        el = cyc - t0;
        n_checks++; if (to) begin n_fail++; $display("FAIL m0_timeout got=1 exp=0"); end
        n_checks++; if (el != XFER) begin n_fail++; $display("FAIL m0_duration got=%0d exp=%0d", el, XFER); end
        n_checks++; if (mon_rises != DB) begin n_fail++; $display("FAIL m0_rises got=%0d exp=%0d", mon_rises, DB); end
        n_checks++; if (mon_bad_gap != 0) begin n_fail++; $display("FAIL m0_rise_spacing got=%0d bad exp=0", mon_bad_gap); end
        n_checks++; if (mon_mosi[DB-1:0] !== 16'hA53C) begin n_fail++; $display("FAIL m0_mosi got=%h exp=a53c", mon_mosi[DB-1:0]); end
        n_checks++; if (cs !== 2'b11) begin n_fail++; $display("FAIL m0_cs_high got=%b exp=11", cs); end
        wb_read(8'h00, d, a);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL m0_status got=%h exp=02", d); end
        for (int k = 0; k < 4; k++) begin
            wb_read(8'(4 + k), d, a);
            n_checks++; if (d !== exp_byte(k, 16'hA53C, slv)) begin n_fail++; $display("FAIL m0_rd%0d got=%h exp=%h", k, d, exp_byte(k, 16'hA53C, slv)); end
        end
    endtask

    task automatic test_mode3;
        logic [7:0]    d;
        logic          a;
        bit            to;
        int unsigned   t0;
        logic [DB-1:0] tx;
        tx = DB'($urandom);
        m_cpol = 1'b1; m_cpha = 1'b1;
        wb_write(8'h01, 8'h03);
        n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_sclk got=%b exp=1", sclk); end
        setup_and_start(tx, 2'b11, 2'd0, 16'h1234, t0);
        wait_idle(to);
        n_checks++; if (to || (cyc - t0) != XFER) begin n_fail++; $display("FAIL m3_duration got=%0d exp=%0d", cyc - t0, XFER); end
        n_checks++; if (mon_mosi[DB-1:0] !== tx) begin n_fail++; $display("FAIL m3_mosi got=%h exp=%h", mon_mosi[DB-1:0], tx); end
        n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_end_sclk got=%b exp=1", sclk); end
        wb_read(8'h04, d, a);
        n_checks++; if (d !== exp_byte(0, tx, 16'h1234)) begin n_fail++; $display("FAIL m3_rd0 got=%h exp=%h", d, exp_byte(0, tx, 16'h1234)); end
        wb_read(8'h05, d, a);
        n_checks++; if (d !== exp_byte(1, tx, 16'h1234)) begin n_fail++; $display("FAIL m3_rd1 got=%h exp=%h", d, exp_byte(1, tx, 16'h1234)); end
    endtask

    task automatic test_cs_select;
        logic [7:0]  d;
        logic        a;
        bit          to;
        bit          any_low;
        int unsigned t0;
        setup_and_start(DB'($urandom), 2'b00, 2'd1, DB'($urandom), t0);
        n_checks++; if (cs !== 2'b01) begin n_fail++; $display("FAIL cs1_low got=%b exp=01", cs); end
        wait_idle(to);
        n_checks++; if (to || mon_cs_low !== 2'b10) begin n_fail++; $display("FAIL cs1_only got=%b exp=10", mon_cs_low); end
        wb_write(8'h00, 8'h05);
        any_low = 1'b0;
        for (int i = 0; i < 3 * HALF; i++) begin
            @(posedge clk); #1;
            if (cs !== 2'b11) any_low = 1'b1;
        end
        n_checks++; if (any_low) begin n_fail++; $display("FAIL cs2_ignored got=activity exp=none"); end
        wb_read(8'h00, d, a);
        n_checks++; if (d[0] !== 1'b0) begin n_fail++; $display("FAIL cs2_busy got=%b exp=0", d[0]); end
    endtask

    task automatic test_ignored_writes;
        logic [7:0]    d;
        logic          a;
        bit            to;
        int unsigned   t0;
        logic [DB-1:0] tx, slv;
        tx = DB'($urandom); slv = DB'($urandom);
        setup_and_start(tx, 2'b00, 2'd0, slv, t0);
        repeat (6 * HALF) @(posedge clk);
        wb_write(8'h04, 8'hFF);
        wb_write(8'h01, 8'h01);
        wb_write(8'h00, 8'h01);
        wait_idle(to);
        n_checks++; if (to || (cyc - t0) != XFER) begin n_fail++; $display("FAIL ign_duration got=%0d exp=%0d", cyc - t0, XFER); end
        n_checks++; if (mon_mosi[DB-1:0] !== tx) begin n_fail++; $display("FAIL ign_mosi got=%h exp=%h", mon_mosi[DB-1:0], tx); end
        n_checks++; if (mon_toggles != 2 * DB) begin n_fail++; $display("FAIL ign_toggles got=%0d exp=%0d", mon_toggles, 2 * DB); end
        wb_read(8'h01, d, a);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL ign_config got=%h exp=00", d); end
        wb_read(8'h04, d, a);
        n_checks++; if (d !== exp_byte(0, tx, slv)) begin n_fail++; $display("FAIL ign_rd0 got=%h exp=%h", d, exp_byte(0, tx, slv)); end
        repeat (2 * HALF) @(posedge clk);
        #1;
        wb_read(8'h00, d, a);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL ign_second_start got=%h exp=02", d); end
    endtask

    task automatic test_reset_mid;
        logic [7:0]    d;
        logic          a;
        bit            to;
        int unsigned   t0;
        logic [DB-1:0] tx;
        setup_and_start(DB'($urandom), 2'b00, 2'd0, DB'($urandom), t0);
        for (int i = 0; i < 4 * XFER && mon_toggles < 7; i++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (mon_toggles != 7) begin n_fail++; $display("FAIL rmid_reach_edge7 got=%0d exp=7", mon_toggles); end
        rst = 1'b1;
        #1;
        n_checks++; if (cs !== 2'b11) begin n_fail++; $display("FAIL rmid_cs got=%b exp=11", cs); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL rmid_sclk got=%b exp=0", sclk); end
        @(negedge clk);
        rst = 1'b0;
        wb_read(8'h00, d, a);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rmid_status got=%h exp=00", d); end
        tx = DB'($urandom);
        setup_and_start(tx, 2'b00, 2'd1, DB'($urandom), t0);
        wait_idle(to);
        n_checks++; if (to || (cyc - t0) != XFER) begin n_fail++; $display("FAIL rmid_after_duration got=%0d exp=%0d", cyc - t0, XFER); end
        n_checks++; if (mon_mosi[DB-1:0] !== tx || mon_samples != DB) begin n_fail++; $display("FAIL rmid_after_data got=%h/%0d exp=%h/%0d", mon_mosi[DB-1:0], mon_samples, tx, DB); end
    endtask

    task automatic test_byte_bounds;
        logic [7:0] d;
        logic       a;
        wb_write(8'h06, 8'hAB);
        wb_write(8'h07, 8'hCD);
        wb_read(8'h06, d, a);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL bound_rd2 got=%h exp=00", d); end
        wb_read(8'h07, d, a);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL bound_rd3 got=%h exp=00", d); end
    endtask

    task automatic test_random;
        logic [7:0]    d;
        logic          a;
        bit            to;
        int unsigned   t0;
        logic [DB-1:0] tx, slv;
        logic [1:0]    mode, csidx;
        for (int it = 0; it < 4; it++) begin
            tx = DB'($urandom); slv = DB'($urandom);
            mode = 2'($urandom_range(0, 3)); csidx = 2'($urandom_range(0, NCS - 1));
            setup_and_start(tx, mode, csidx, slv, t0);
            wait_idle(to);
            n_checks++; if (to || (cyc - t0) != XFER) begin n_fail++; $display("FAIL rnd%0d_duration got=%0d exp=%0d", it, cyc - t0, XFER); end
            n_checks++; if (mon_mosi[DB-1:0] !== tx) begin n_fail++; $display("FAIL rnd%0d_mosi mode=%0d got=%h exp=%h", it, mode, mon_mosi[DB-1:0], tx); end
            n_checks++; if (mon_toggles != 2 * DB || mon_samples != DB) begin n_fail++; $display("FAIL rnd%0d_edges got=%0d/%0d exp=%0d/%0d", it, mon_toggles, mon_samples, 2 * DB, DB); end
            n_checks++; if (mon_cs_low !== NCS'(1 << csidx)) begin n_fail++; $display("FAIL rnd%0d_cs got=%b exp=%b", it, mon_cs_low, NCS'(1 << csidx)); end
            n_checks++; if (sclk !== mode[0]) begin n_fail++; $display("FAIL rnd%0d_idle_sclk got=%b exp=%b", it, sclk, mode[0]); end
            for (int k = 0; k < DB / 8; k++) begin
                wb_read(8'(4 + k), d, a);
                n_checks++; if (d !== exp_byte(k, tx, slv)) begin n_fail++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", it, k, d, exp_byte(k, tx, slv)); end
            end
        end
    endtask

    initial begin
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = '0;   bus.wb_dat_i = '0;
        #1;
        test_reset();
        test_mode0();
        test_mode3();
        test_cs_select();
        test_ignored_writes();
        test_reset_mid();
        test_byte_bounds();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
